// File: rtl/l2_ewb.sv
// ---------------------------------------------------------------------------
// l2_ewb -- eviction write buffer between the L2 memory-side port and memory.
//
// Dirty-line writebacks from L2 are absorbed into a small circular FIFO and
// acknowledged without waiting for memory. Reads that hit a buffered line are
// served from the buffer; read misses go straight to memory. Buffered lines
// are written back to memory whenever the L2 side is idle, or when a new
// writeback finds the FIFO full.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   mem_read      L2 line read request (held until mem_resp)
//   mem_write     L2 writeback request (held until mem_resp)
//   mem_address   L2 request address (low s_offset bits ignored)
//   mem_wdata256  writeback data
//   mem_rdata256  read data, valid while mem_resp=1, holds otherwise
//   mem_resp      one-cycle completion pulse to L2
//   pmem_read     memory line read (held until pmem_resp)
//   pmem_write    memory line write (held until pmem_resp)
//   pmem_address  line-aligned memory address
//   pmem_wdata    memory write data (FIFO head entry)
//   pmem_rdata    memory read data, valid with pmem_resp
//   pmem_resp     memory completion pulse
// ---------------------------------------------------------------------------
module l2_ewb #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int depth    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [s_line-1:0] mem_wdata256,
  output logic [s_line-1:0] mem_rdata256,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int TagW = 32 - s_offset;
  localparam int PtrW = $clog2(depth);
  localparam int CntW = $clog2(depth + 1);
  localparam logic [CntW-1:0] Full = CntW'(depth);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    READ,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [s_line-1:0] rdata_q, rdata_d;
  logic [31:0]       addr_q, addr_d;

  logic [depth-1:0]  valid_q;
  logic [TagW-1:0]   tag_q  [depth];
  logic [s_line-1:0] data_q [depth];

  logic [TagW-1:0] req_tag;
  logic [31:0]     head_addr;
  logic            hit;
  logic [PtrW-1:0] hit_idx;

  // Entry update controls produced by the next-state logic.
  logic            data_we;
  logic [PtrW-1:0] data_widx;
  logic            alloc;
  logic            clr_head;

  // Offset bits of the request address carry no meaning for a line buffer.
  logic unused_offset_bits;
  assign unused_offset_bits = ^mem_address[s_offset-1:0];

  assign req_tag   = mem_address[31:s_offset];
  assign head_addr = {tag_q[head_q], {s_offset{1'b0}}};

  // Associative lookup over every valid entry; the coalescing invariant
  // guarantees at most one match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < depth; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PtrW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    data_we   = 1'b0;
    data_widx = tail_q;
    alloc     = 1'b0;
    clr_head  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_read) begin
          if (hit) begin
            rdata_d = data_q[hit_idx];
            state_d = RESP;
          end else begin
            addr_d  = {req_tag, {s_offset{1'b0}}};
            state_d = READ;
          end
        end else if (mem_write) begin
          if (hit) begin
            // Coalesce into the existing entry; occupancy is unchanged.
            data_we   = 1'b1;
            data_widx = hit_idx;
            state_d   = RESP;
          end else if (count_q != Full) begin
            data_we   = 1'b1;
            data_widx = tail_q;
            alloc     = 1'b1;
            tail_d    = tail_q + PtrW'(1);
            count_d   = count_q + CntW'(1);
            state_d   = RESP;
          end else begin
            // Full: free the head first, the write is re-evaluated afterwards.
            addr_d  = head_addr;
            state_d = DRAIN;
          end
        end else if (count_q != '0) begin
          addr_d  = head_addr;
          state_d = DRAIN;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      READ: begin
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = RESP;
        end
      end

      DRAIN: begin
        if (pmem_resp) begin
          clr_head = 1'b1;
          head_d   = head_q + PtrW'(1);
          count_d  = count_q - CntW'(1);
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < depth; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tag_q[tail_q]   <= req_tag;
      end
      if (clr_head) begin
        valid_q[head_q] <= 1'b0;
      end
    end
  end

  // Line data needs no reset: an entry is only read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[data_widx] <= mem_wdata256;
    end
  end

  assign mem_resp     = (state_q == RESP);
  assign pmem_read    = (state_q == READ);
  assign pmem_write   = (state_q == DRAIN);
  assign pmem_address = addr_q;
  assign pmem_wdata   = data_q[head_q];
  assign mem_rdata256 = rdata_q;

endmodule

// File: tb/tb_l2_ewb.sv
// ---------------------------------------------------------------------------
// tb_l2_ewb -- self-checking bench for the L2 eviction write buffer.
//
// The reference view is the whole memory system: a read must return the
// latest data written to that line, wherever it currently lives. Memory is
// an associative array behind a behavioural responder with adjustable
// latency; drained lines are logged in arrival order.
// ---------------------------------------------------------------------------
module tb_l2_ewb;

  localparam int LineW = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_read;
  logic             mem_write;
  logic [31:0]      mem_address;
  logic [LineW-1:0] mem_wdata256;
  logic [LineW-1:0] mem_rdata256;
  logic             mem_resp;
  logic             pmem_read;
  logic             pmem_write;
  logic [31:0]      pmem_address;
  logic [LineW-1:0] pmem_wdata;
  logic [LineW-1:0] pmem_rdata;
  logic             pmem_resp;

  int total = 0;
  int bad   = 0;

  int memLatency = 2;
  bit holdResp   = 1'b0;
  int waitCnt    = 0;

  logic [LineW-1:0] memArr [logic [31:0]];
  logic [LineW-1:0] golden [logic [31:0]];
  logic [31:0]      drainAddr [$];
  logic [LineW-1:0] drainData [$];

  int          readCycles = 0;
  logic [31:0] lastReadAddr = '0;

  l2_ewb dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata256 (mem_wdata256),
    .mem_rdata256 (mem_rdata256),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lineOf(input logic [31:0] a);
    return {a[31:5], 5'b00000};
  endfunction

  // Contents of a memory line that has never been written.
  function automatic logic [LineW-1:0] initVal(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1, a * 32'd3, ~a + 32'd7,
            a ^ 32'hFFFF_0000, a - 32'd9};
  endfunction

  function automatic logic [LineW-1:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return initVal(a);
  endfunction

  // Latest architecturally visible data for a line.
  function automatic logic [LineW-1:0] expectedRead(input logic [31:0] a);
    logic [31:0] l;
    l = lineOf(a);
    if (golden.exists(l)) return golden[l];
    return memRead(l);
  endfunction

  function automatic logic [LineW-1:0] randLine();
    logic [LineW-1:0] v;
    for (int i = 0; i < LineW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Memory responder: counts cycles at the falling edge while a request is
  // held and raises a one-cycle pmem_resp once the latency has elapsed.
  // Writes land in memArr at that moment and are logged in order.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      waitCnt    = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
    end else if (pmem_read || pmem_write) begin
      waitCnt++;
      if (waitCnt >= memLatency && !holdResp) begin
        pmem_resp = 1'b1;
        waitCnt   = 0;
        if (pmem_write) begin
          memArr[pmem_address] = pmem_wdata;
          drainAddr.push_back(pmem_address);
          drainData.push_back(pmem_wdata);
        end else begin
          pmem_rdata = memRead(pmem_address);
        end
      end
    end
  end

  // Tracks how long memory reads are held and where they point.
  always @(negedge clk) begin
    if (rst && pmem_read) begin
      readCycles++;
      lastReadAddr = pmem_address;
    end
  end

  // Memory read and write must never be requested together.
  always @(negedge clk) begin
    if (rst && (pmem_read || pmem_write)) begin
      checkOutput("pmem_excl", LineW'(pmem_read & pmem_write), '0);
    end
  end

  task automatic checkOutput(input string tag, input logic [LineW-1:0] observed,
                             input logic [LineW-1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic driveReq(input bit isWrite, input logic [31:0] addr,
                          input logic [LineW-1:0] data);
    mem_read     = !isWrite;
    mem_write    = isWrite;
    mem_address  = addr;
    mem_wdata256 = data;
  endtask

  // Waits for mem_resp; with keep set the request lines stay up so the
  // caller can chain the next request straight into the response cycle.
  task automatic waitResp(input string tag, input bit keep,
                          output logic [LineW-1:0] rdata);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      #1;
      if (mem_resp) got = 1'b1;
    end
    checkOutput({tag, "_resp"}, LineW'(got), LineW'(1));
    rdata = mem_rdata256;
    if (!keep) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  task automatic applyStimulus(input string tag, input bit isWrite,
                               input logic [31:0] addr, input logic [LineW-1:0] data,
                               input bit keep, output logic [LineW-1:0] rdata);
    driveReq(isWrite, addr, data);
    waitResp(tag, keep, rdata);
    if (isWrite) golden[lineOf(addr)] = data;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits until the buffer has fully drained (memory port quiet).
  task automatic waitIdle(input string tag);
    int quiet;
    quiet = 0;
    for (int i = 0; i < 3000 && quiet < 12; i++) begin
      @(posedge clk);
      #1;
      if (pmem_read || pmem_write) quiet = 0;
      else quiet++;
    end
    checkOutput({tag, "_idle"}, LineW'(quiet >= 12), LineW'(1));
  endtask

  task automatic waitPmemWrite(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (pmem_write) seen = 1'b1;
    end
    checkOutput({tag, "_pwr"}, LineW'(seen), LineW'(1));
  endtask

  initial begin
    logic [LineW-1:0] rd;
    logic [LineW-1:0] d0;
    logic [LineW-1:0] d1;
    logic [LineW-1:0] exp;
    logic [31:0]      a4 [5];
    logic [LineW-1:0] d4 [5];

    rst          = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_wdata256 = '0;

    // Reset state.
    #2;
    checkOutput("rst_mem_resp", LineW'(mem_resp), '0);
    checkOutput("rst_pmem_read", LineW'(pmem_read), '0);
    checkOutput("rst_pmem_write", LineW'(pmem_write), '0);
    checkOutput("rst_pmem_addr", LineW'(pmem_address), '0);
    checkOutput("rst_rdata", mem_rdata256, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(2);

    // 1: single write, acknowledged without memory, then drained when idle.
    $display("[TB] single write and idle drain");
    memLatency = 3;
    drainAddr.delete();
    drainData.delete();
    d0 = randLine();
    applyStimulus("t1_wr", 1'b1, 32'h0000_1040, d0, 1'b0, rd);
    checkOutput("t1_no_pmem", LineW'({pmem_read, pmem_write}), '0);
    cycles(1);
    checkOutput("t1_resp_pulse", LineW'(mem_resp), '0);
    waitPmemWrite("t1");
    checkOutput("t1_drain_addr", LineW'(pmem_address), LineW'(32'h0000_1040));
    checkOutput("t1_drain_data", pmem_wdata, d0);
    waitIdle("t1");
    checkOutput("t1_drain_count", LineW'(drainAddr.size()), LineW'(1));

    // 2: read hits a freshly buffered line.
    $display("[TB] read hit on buffered line");
    readCycles = 0;
    d0 = randLine();
    applyStimulus("t2_wr", 1'b1, 32'h0000_2000, d0, 1'b1, rd);
    applyStimulus("t2_rd", 1'b0, 32'h0000_2010, '0, 1'b0, rd);
    checkOutput("t2_hit_data", rd, d0);
    checkOutput("t2_no_pmem_read", LineW'(readCycles), '0);
    waitIdle("t2");

    // 3: read miss with memory latency 5.
    $display("[TB] read miss");
    memLatency = 5;
    readCycles = 0;
    exp = expectedRead(32'h0000_3014);
    applyStimulus("t3_rd", 1'b0, 32'h0000_3014, '0, 1'b0, rd);
    checkOutput("t3_read_cycles", LineW'(readCycles), LineW'(5));
    checkOutput("t3_read_addr", LineW'(lastReadAddr), LineW'(32'h0000_3000));
    checkOutput("t3_read_done", LineW'(pmem_read), '0);
    checkOutput("t3_data", rd, exp);

    // 4: fill the FIFO back-to-back, the fifth write forces a drain.
    $display("[TB] full buffer forced drain");
    waitIdle("t4a");
    drainAddr.delete();
    drainData.delete();
    holdResp   = 1'b1;
    memLatency = 2;
    for (int i = 0; i < 5; i++) begin
      a4[i] = 32'h0000_5000 + 32'(i) * 32'h20;
      d4[i] = randLine();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus("t4_wr", 1'b1, a4[i], d4[i], 1'b1, rd);
    end
    driveReq(1'b1, a4[4], d4[4]);
    cycles(8);
    checkOutput("t4_forced_drain", LineW'(pmem_write), LineW'(1));
    checkOutput("t4_forced_addr", LineW'(pmem_address), LineW'(a4[0]));
    checkOutput("t4_forced_data", pmem_wdata, d4[0]);
    checkOutput("t4_w5_waits", LineW'(mem_resp), '0);
    holdResp = 1'b0;
    waitResp("t4_w5", 1'b0, rd);
    golden[a4[4]] = d4[4];
    checkOutput("t4_drain_first", LineW'(drainAddr.size()), LineW'(1));
    waitIdle("t4b");
    checkOutput("t4_drain_total", LineW'(drainAddr.size()), LineW'(5));
    for (int i = 0; i < 5 && i < drainAddr.size(); i++) begin
      checkOutput("t4_order_addr", LineW'(drainAddr[i]), LineW'(a4[i]));
      checkOutput("t4_order_data", drainData[i], d4[i]);
    end

    // 5: two writes to one line coalesce into a single drain.
    $display("[TB] write coalescing");
    drainAddr.delete();
    drainData.delete();
    d0 = randLine();
    d1 = randLine();
    applyStimulus("t5_wr1", 1'b1, 32'h0000_4000, d0, 1'b1, rd);
    applyStimulus("t5_wr2", 1'b1, 32'h0000_4000, d1, 1'b0, rd);
    waitIdle("t5");
    checkOutput("t5_drain_count", LineW'(drainAddr.size()), LineW'(1));
    if (drainAddr.size() > 0) begin
      checkOutput("t5_drain_addr", LineW'(drainAddr[0]), LineW'(32'h0000_4000));
      checkOutput("t5_drain_data", drainData[0], d1);
    end

    // Random mix of reads and writes over six lines with random latency.
    $display("[TB] random traffic");
    for (int n = 0; n < 60; n++) begin
      int          gap;
      bit          isWrite;
      logic [31:0] addr;
      gap        = $urandom_range(0, 3);
      isWrite    = 1'($urandom_range(0, 1));
      addr       = 32'h0000_7000 + 32'($urandom_range(0, 5)) * 32'h20
                   + 32'($urandom_range(0, 31));
      memLatency = $urandom_range(1, 4);
      d0         = randLine();
      exp        = expectedRead(addr);
      applyStimulus("rnd", isWrite, addr, d0, gap == 0, rd);
      if (!isWrite) checkOutput("rnd_rd_data", rd, exp);
      cycles(gap);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    waitIdle("rnd");
    foreach (golden[k]) begin
      checkOutput("rnd_mem_final", memRead(k), golden[k]);
    end

    // 6: reset in the middle of a drain discards the buffered line.
    $display("[TB] reset during drain");
    holdResp = 1'b1;
    d0 = randLine();
    applyStimulus("t6_wr", 1'b1, 32'h0000_6000, d0, 1'b0, rd);
    waitPmemWrite("t6");
    cycles(2);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_pmem_write", LineW'(pmem_write), '0);
    checkOutput("t6_mem_resp", LineW'(mem_resp), '0);
    checkOutput("t6_pmem_addr", LineW'(pmem_address), '0);
    checkOutput("t6_rdata", mem_rdata256, '0);
    golden.delete();
    holdResp   = 1'b0;
    memLatency = 2;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(1);
    readCycles = 0;
    exp = expectedRead(32'h0000_6000);
    applyStimulus("t6_rd", 1'b0, 32'h0000_6000, '0, 1'b0, rd);
    checkOutput("t6_read_miss", LineW'(readCycles != 0), LineW'(1));
    checkOutput("t6_read_data", rd, exp);

    cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
